// File: rtl/mem_unit.sv
// mem_unit: word-addressed data memory with req/done handshake and WAIT_CYCLES wait states.
// Sits between the MBR memory-side port and the register array; models a slow memory.
// Optional build macro MEM_UNIT_BOUNDS_CHECK_EN: out-of-range addresses complete with err=1,
// no write and rdata=0. Without it the address wraps to the low log2(DEPTH) bits and err is 0.
module mem_unit #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

   state_e            state;
   logic [3:0]        cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [IdxW-1:0]   idx;
   logic              oob;

   logic [DATA_W-1:0] mem [DEPTH];

   // Out-of-range addresses use the low index bits; only the bounds-check build flags them.
   assign idx = addr_q[IdxW-1:0];

`ifdef MEM_UNIT_BOUNDS_CHECK_EN
   localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);
   assign oob = ({1'b0, addr_q} >= DepthExt);
`else
   logic unused_addr;
   assign oob         = 1'b0;
   assign unused_addr = ^addr_q;
`endif

   // Handshake FSM; all outputs registered, latched request fields held for the whole access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (req) begin
                  we_q    <= we;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  busy    <= 1'b1;
                  cnt     <= WaitInit;
                  state   <= (WaitInit == 4'd0) ? StAccess : StWait;
               end
            end
            StWait: begin
               cnt <= cnt - 4'd1;
               // Leave on the edge where the counter reaches zero.
               if (cnt == 4'd1) begin
                  state <= StAccess;
               end
            end
            StAccess: begin
               if (!we_q) begin
                  rdata <= oob ? '0 : mem[idx];
               end
               err   <= oob;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Array write on the ACCESS closing edge; reset forces IDLE so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (state == StAccess && we_q && !oob) begin
         mem[idx] <= wdata_q;
      end
   end

endmodule
